router_fifo: RTL and testbench

Per-port output FIFO of the 1x3 router. One instance sits downstream of the synchronizer on each of the three output ports. It buffers header, payload and parity bytes written under `write_enb[n]` and returns `full`/`empty` to the synchronizer. It tracks packet boundaries through a stored header flag and a payload counter, and flushes itself on the synchronizer's `soft_reset[n]` timeout.

---
 rtl/router_fifo.sv | 96 +++++++++
 tb/tb_router_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: buffers header/payload/parity bytes and tracks packet length.
// Optional sticky overflow/underflow flags are built in when ROUTER_FIFO_ERR_EN is defined.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [6:0]     pkt_cnt;
  logic           wr_acc;
  logic           rd_acc;
  logic           flush;
  logic [WIDTH:0] rd_entry;

  // Extra pointer MSB distinguishes a full ring from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign flush    = reset || soft_reset;
  assign wr_acc   = write_enb && !full && !flush;
  assign rd_acc   = read_enb && !empty && !flush;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A header's length field plus one (for parity) tells how many more bytes belong to the packet.
  always_ff @(posedge clk) begin
    if (flush) begin
      pkt_cnt  <= '0;
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= rd_entry[WIDTH-1:0];
      if (rd_entry[WIDTH]) begin
        pkt_cnt <= {1'b0, rd_entry[7:2]} + 7'd1;
      end else if (pkt_cnt != 7'd0) begin
        pkt_cnt <= pkt_cnt - 7'd1;
      end
    end else if (pkt_cnt == 7'd0) begin
      data_out <= '0;
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enb && full) begin
        overflow <= 1'b1;
      end
      if (read_enb && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo against a queue-based packet model.
// Checks the error flags only when ROUTER_FIFO_ERR_EN is defined.
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef ROUTER_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8:0] q[$];
  int         m_pkt = 0;
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  always #5 clk = ~clk;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .soft_reset(soft_reset),
    .write_enb(write_enb),
    .read_enb(read_enb),
    .lfd_state(lfd_state),
    .data_in(data_in),
    .data_out(data_out),
    .full(full),
    .empty(empty)
`ifdef ROUTER_FIFO_ERR_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  // Drive one cycle of inputs, advance the model by the rules, then settle 1ns past the edge.
  task automatic cycle(input logic r, input logic s, input logic we, input logic re,
                       input logic lfd, input logic [7:0] d);
    logic       was_full;
    logic       was_empty;
    logic [8:0] e;
    reset = r; soft_reset = s; write_enb = we; read_enb = re; lfd_state = lfd; data_in = d;
    @(posedge clk);
    if (r || s) begin
      q.delete();
      m_pkt = 0;
      m_dout = 8'h00;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      was_full = (q.size() == 16);
      was_empty = (q.size() == 0);
      if (we && was_full) m_ovf = 1'b1;
      if (re && was_empty) m_udf = 1'b1;
      if (re && !was_empty) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_pkt = int'(e[7:2]) + 1;
        else if (m_pkt != 0) m_pkt = m_pkt - 1;
      end else if (m_pkt == 0) begin
        m_dout = 8'h00;
      end
      if (we && !was_full) q.push_back({lfd, d});
    end
    #1;
    reset = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 8'h00);
    cycle(1, 0, 1, 1, 1, 8'h77);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h exp 00", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
`ifdef ROUTER_FIFO_ERR_EN
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b%b exp 00", overflow, underflow); end
`endif
  endtask

  task automatic test_packet();
    logic [7:0] pkt [5] = '{8'h0E, 8'h11, 8'h22, 8'h33, 8'h5A};
    cycle(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 0, (i == 0), pkt[i]);
      if (i == 0) begin
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pkt_empty_drop got %b exp 0", empty); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 0, 8'h00);
      checks++; if (data_out !== pkt[i] || data_out !== m_dout) begin
        errors++; $display("FAIL pkt_read%0d got %h exp %h", i, data_out, pkt[i]);
      end
    end
    cycle(0, 0, 0, 0, 0, 8'h00);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL pkt_idle_zero got %h exp 00", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pkt_empty got %b exp 1", empty); end
  endtask

  task automatic test_full();
    logic [7:0] d [16];
    cycle(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      d[i] = 8'($urandom);
      cycle(0, 0, 1, 0, 0, d[i]);
      if (i == 14) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at15 got %b exp 0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_at16 got %b exp 1", full); end
    cycle(0, 0, 1, 0, 0, 8'hFF);
    checks++; if (full !== 1'b1 || q.size() != 16) begin errors++; $display("FAIL full_drop got %b exp 1", full); end
`ifdef ROUTER_FIFO_ERR_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow got %b exp 1", overflow); end
`endif
    cycle(0, 0, 1, 1, 0, 8'hEE);
    checks++; if (data_out !== d[0]) begin errors++; $display("FAIL full_rw_data got %h exp %h", data_out, d[0]); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_rw_full got %b exp 0", full); end
    for (int i = 1; i < 16; i++) begin
      cycle(0, 0, 0, 1, 0, 8'h00);
      checks++; if (data_out !== d[i]) begin errors++; $display("FAIL full_order%0d got %h exp %h", i, data_out, d[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b exp 1", empty); end
  endtask

  task automatic test_empty_rw();
    cycle(1, 0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 1, 0, 8'hA5);
    checks++; if (data_out !== m_dout) begin errors++; $display("FAIL erw_data got %h exp %h", data_out, m_dout); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL erw_empty got %b exp 0", empty); end
`ifdef ROUTER_FIFO_ERR_EN
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow got %b exp 1", underflow); end
`endif
    cycle(0, 0, 0, 1, 0, 8'h00);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL erw_read got %h exp a5", data_out); end
  endtask

  // Header held across an idle cycle, then a flush (soft or hard) mid-packet.
  task automatic flush_case(input logic use_reset, input string tag);
    cycle(1, 0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 1, 8'h0C);
    for (int i = 1; i < 8; i++) cycle(0, 0, 1, 0, 0, 8'(i * 16 + i));
    cycle(0, 0, 0, 1, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'h00);
    checks++; if (data_out !== 8'h0C) begin errors++; $display("FAIL %s_hold got %h exp 0c", tag, data_out); end
    cycle(use_reset, !use_reset, 1, 1, 0, 8'h99);
    checks++; if (empty !== 1'b1 || data_out !== 8'h00) begin
      errors++; $display("FAIL %s_flush got empty=%b data=%h exp 1 00", tag, empty, data_out);
    end
    cycle(0, 0, 1, 0, 0, 8'h42);
    cycle(0, 0, 0, 1, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'h00);
    checks++; if (data_out !== 8'h00 || empty !== 1'b1) begin
      errors++; $display("FAIL %s_after got data=%h empty=%b exp 00 1", tag, data_out, empty);
    end
  endtask

  task automatic test_soft_reset();
    flush_case(1'b0, "soft");
    flush_case(1'b1, "hard");
  endtask

  task automatic test_wrap();
    int written = 0;
    int cyc = 0;
    logic we, re;
    cycle(1, 0, 0, 0, 0, 8'h00);
    while ((written < 40 || q.size() != 0) && cyc < 1000) begin
      we = (written < 40) && (q.size() < 16) && ($urandom_range(0, 2) != 0);
      re = ($urandom_range(0, 2) == 0) || (written >= 40);
      if (we) written++;
      cycle(0, 0, we, re, ($urandom_range(0, 5) == 0), 8'($urandom));
      cyc++;
      checks++; if (data_out !== m_dout || full !== (q.size() == 16) || empty !== (q.size() == 0)) begin
        errors++; $display("FAIL wrap_c%0d got %h %b%b exp %h %b%b", cyc, data_out, full, empty,
                           m_dout, (q.size() == 16), (q.size() == 0));
      end
    end
    checks++; if (cyc >= 1000) begin errors++; $display("FAIL wrap_timeout got %0d cycles exp <1000", cyc); end
  endtask

  task automatic test_random();
    logic r, s;
    cycle(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 49) == 0);
      cycle(r, s, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) == 0, 8'($urandom));
      checks++; if (data_out !== m_dout || full !== (q.size() == 16) || empty !== (q.size() == 0)) begin
        errors++; $display("FAIL rand_c%0d got %h %b%b exp %h %b%b", i, data_out, full, empty,
                           m_dout, (q.size() == 16), (q.size() == 0));
      end
`ifdef ROUTER_FIFO_ERR_EN
      checks++; if (overflow !== m_ovf || underflow !== m_udf) begin
        errors++; $display("FAIL rand_err%0d got %b%b exp %b%b", i, overflow, underflow, m_ovf, m_udf);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_full();
    test_empty_rw();
    test_soft_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
